spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
// - Mode-0 SPI bus master (CPOL=0, CPHA=0), MSB first, SSEL active low, 8-bit frames.
// - Drives SCK/MOSI/SSEL into the FPGA-side SPI slave and samples its MISO.
// - The slave oversamples SCK with a 3-flop synchroniser, so the SCK half-period is
//   several system clocks long.
// - Host side is a byte stream with valid/ready; multi-byte bursts keep SSEL low.
// PARAMETERS
// - CLK_DIV   default 4   SCK half-period H in clk cycles; legal range 2..255.
// PORTS
// - clk        in   1  system clock; all logic on its rising edge
// - rst_n      in   1  asynchronous, active-low reset
// - tx_valid   in   1  host offers tx_data/tx_last
// - tx_ready   out  1  master accepts the byte this cycle when tx_valid=1
// - tx_data    in   8  byte to shift out on MOSI, MSB first
// - tx_last    in   1  byte ends the burst; SSEL deasserts after it
// - rx_valid   out  1  one-cycle pulse; rx_data holds the byte sampled from MISO
// - rx_data    out  8  last received byte; held until the next rx_valid
// - busy       out  1  high whenever state != IDLE
// - SCK        out  1  SPI clock, idle low
// - MOSI       out  1  master data out
// - MISO       in   1  slave data in
// - SSEL       out  1  slave select, active low
// BEHAVIOUR
// - Reset values (asynchronous): SCK=0, SSEL=1, MOSI=0, tx_ready=0, rx_valid=0,
//   rx_data=8'h00, busy=0, state=IDLE.
// - tx_ready is combinational from state: 1 in IDLE and WAIT only.
// - A byte is accepted on a cycle where tx_valid && tx_ready. tx_valid is ignored in
//   all other states.
// - FSM states:
//   - IDLE: on accept, latch shift register and last flag; go to SETUP.
//   - SETUP: entered on the cycle after accept. SSEL=0, MOSI=bit7, SCK=0.
//     Lasts H cycles, then go to SHIFT.
//   - SHIFT: SCK toggles every H cycles, 8 rising and 8 falling edges.
//     - On each SCK rise, sample MISO into the shift register LSB.
//     - On each SCK fall except the 8th, present the next bit on MOSI.
//     - Bit counter is 3 bits and wraps 7->0.
//     - 8th fall: rx_data <= shift register and rx_valid=1 for exactly 1 cycle.
//       Go to HOLD if last, otherwise WAIT.
//   - WAIT: SSEL=0, SCK=0, tx_ready=1.
//     - On accept, go straight to SHIFT with MOSI=bit7 and no SETUP.
//     - Stays in WAIT indefinitely with no timeout.
//   - HOLD: H cycles with SSEL=0, SCK=0, then SSEL=1 and go to GAP.
//   - GAP: H cycles with SSEL=1, then go to IDLE. This guarantees the slave sees
//     the SSEL rising edge.
// - Single-byte latency, counted from the accept cycle t:
//   - SSEL falls at t+1.
//   - First SCK rise at t+1+H.
//   - rx_valid at t+1+17H.
//   - SSEL rises at t+1+18H.
//   - tx_ready next high at t+1+19H.
// - Within a burst, the next byte's first SCK rise comes H cycles after the accept
//   cycle in WAIT.
// - MISO is not resynchronised. It is sampled on the cycle SCK is driven high;
//   the slave changes MISO only after its own synchronised SCK fall.
// - Reset mid-transfer: SSEL=1 and SCK=0 take effect immediately, with no partial
//   rx_valid. The slave discards the partial byte on SSEL high.
// - A CLK_DIV outside 2..255 is a static error (elaboration $error).
// CONFIGURATION
// - SPI_LOOPBACK_EN defined: the MISO sample point takes the MOSI register instead
//   of the MISO pin, so rx_data equals the transmitted byte. The MISO port is
//   present but unused.
// - SPI_LOOPBACK_EN undefined (default): MISO pin sampled as described above.
// TESTING
// - Single byte, CLK_DIV=4, tx_data=8'hA5, tx_last=1, slave model returns 8'h3C:
//   - MOSI at the 8 rises = 1,0,1,0,0,1,0,1.
//   - rx_data=8'h3C with rx_valid high exactly 1 cycle at t+69.
//   - SSEL high at t+73; tx_ready high at t+77.
// - Burst 8'h05 (last=0) then 8'h11 (last=1):
//   - SSEL stays low throughout; 16 SCK rises.
//   - Two rx_valid pulses. With the reference slave model, the second rx_data is
//     8'h0A (reply to 8'h05).
// - Stall: after 8'h01 with last=0, hold tx_valid=0 for 50 cycles:
//   - SSEL=0, SCK=0, tx_ready=1 for all 50 cycles.
//   - Then 8'hFF with last=1 completes normally.
// - Reset: assert rst_n=0 after the 3rd SCK rise:
//   - Same cycle: SSEL=1, SCK=0, MOSI=0, busy=0, no rx_valid.
//   - After release, 8'h5A transfers correctly.
// - tx_valid held high continuously with last=1:
//   - SSEL stays high at least 4 cycles between frames.
//   - No byte is accepted while busy.
// - With SPI_LOOPBACK_EN defined and MISO tied to 0, sending 8'hC3 gives rx_data=8'hC3.

Source files
------------

// File: rtl/spi_master_if.sv
// Host byte-stream handshake plus SPI pins for spi_master.
interface spi_master_if;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       busy;
   logic       SCK;
   logic       MOSI;
   logic       MISO;
   logic       SSEL;

   modport master (
      input  tx_valid, tx_data, tx_last, MISO,
      output tx_ready, rx_valid, rx_data, busy, SCK, MOSI, SSEL
   );

   modport slave (
      output tx_valid, tx_data, tx_last, MISO,
      input  tx_ready, rx_valid, rx_data, busy, SCK, MOSI, SSEL
   );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first, 8-bit frames, SSEL held low across bursts.
// Define SPI_LOOPBACK_EN to sample the MOSI register instead of the MISO pin.
module spi_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   spi_master_if.master  bus_io
);

   if ((CLK_DIV < 2) || (CLK_DIV > 255)) begin : g_bad_div
      $error("spi_master: CLK_DIV must be in 2..255");
   end

   localparam logic [7:0] HalfLast = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StShift, StWait, StHold, StGap} state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic       last_q, last_d;
   logic       lead_q, lead_d;
   logic       sck_q, sck_d;
   logic       mosi_q, mosi_d;
   logic       rx_valid_q, rx_valid_d;
   logic [7:0] rx_data_q, rx_data_d;

   logic       tx_ready_w;
   logic       accept;
   logic       tick;
   logic       sample_bit;

`ifdef SPI_LOOPBACK_EN
   assign sample_bit = mosi_q;
`else
   assign sample_bit = bus_io.MISO;
`endif

   assign accept = bus_io.tx_valid && tx_ready_w;
   assign tick   = (cnt_q == HalfLast);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         bit_q      <= 3'd0;
         shift_q    <= 8'd0;
         last_q     <= 1'b0;
         lead_q     <= 1'b0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         last_q     <= last_d;
         lead_q     <= lead_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      last_d     = last_q;
      lead_d     = lead_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StSetup;
               shift_d = bus_io.tx_data;
               last_d  = bus_io.tx_last;
               mosi_d  = bus_io.tx_data[7];
               cnt_d   = 8'd0;
               bit_d   = 3'd0;
               lead_d  = 1'b0;
            end
         end
         StSetup: begin
            if (tick) begin
               state_d = StShift;
               cnt_d   = 8'd0;
               sck_d   = 1'b1;
               shift_d = {shift_q[6:0], sample_bit};
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StShift: begin
            if (!tick) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = 8'd0;
               if (sck_q) begin
                  sck_d = 1'b0;
                  bit_d = bit_q + 3'd1;
                  if (bit_q != 3'd7) mosi_d = shift_q[7];
               end else if ((bit_q == 3'd0) && !lead_q) begin
                  // Low half after the 8th fall has elapsed: frame complete.
                  rx_valid_d = 1'b1;
                  rx_data_d  = shift_q;
                  state_d    = last_q ? StHold : StWait;
               end else begin
                  sck_d   = 1'b1;
                  lead_d  = 1'b0;
                  shift_d = {shift_q[6:0], sample_bit};
               end
            end
         end
         StWait: begin
            if (accept) begin
               // Preloaded count gives the first rise H cycles after accept.
               state_d = StShift;
               shift_d = bus_io.tx_data;
               last_d  = bus_io.tx_last;
               mosi_d  = bus_io.tx_data[7];
               cnt_d   = 8'd1;
               bit_d   = 3'd0;
               lead_d  = 1'b1;
            end
         end
         StHold: begin
            if (tick) begin
               state_d = StGap;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StGap: begin
            if (tick) begin
               state_d = StIdle;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tx_ready_w      = rst_n && ((state_q == StIdle) || (state_q == StWait));
      bus_io.tx_ready = tx_ready_w;
      bus_io.busy     = (state_q != StIdle);
      bus_io.SSEL     = (state_q == StIdle) || (state_q == StGap);
      bus_io.SCK      = sck_q;
      bus_io.MOSI     = mosi_q;
      bus_io.rx_valid = rx_valid_q;
      bus_io.rx_data  = rx_data_q;
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural mode-0 slave on the pins.
module tb_spi_master;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_master_if bus ();

   spi_master #(.CLK_DIV(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] reply);
`ifdef SPI_LOOPBACK_EN
      return tx;
`else
      return reply;
`endif
   endfunction

   // Slave: first reply byte per SSEL assertion, then echoes each received byte << 1.
   logic [7:0] slave_first = 8'h3C;
   logic       slave_mute = 1'b0;
   logic [7:0] s_in = 8'h00;
   logic [7:0] s_out = 8'h00;
   int         s_bits = 0;

   always @(posedge bus.SCK or posedge bus.SSEL) begin
      if (bus.SSEL === 1'b1) s_bits = 0;
      else begin
         s_in = {s_in[6:0], bus.MOSI};
         s_bits++;
      end
   end

   always @(negedge bus.SSEL or negedge bus.SCK) begin
      if (s_bits == 0) s_out = slave_first;
      else if (s_bits % 8 == 0) s_out = s_in << 1;
      else s_out = s_out << 1;
      bus.MISO = slave_mute ? 1'b0 : s_out[7];
   end

   // Event monitor, sampled mid-cycle.
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rise_cnt = 0, ssel_fall_cnt = 0, ssel_rise_cnt = 0, rxv_cnt = 0, hi_run = 0;
   int ssel_fall_cyc = 0, ssel_rise_cyc = 0, rdy_rise_cyc = 0, rxv_cyc = 0;
   int rise_cyc[$];
   int gap_log[$];
   logic [7:0] rx_log[$];
   logic p_sck = 1'b0, p_ssel = 1'b1, p_rdy = 1'b0;

   always @(negedge clk) begin
      if (bus.SCK === 1'b1 && p_sck === 1'b0) begin
         rise_cnt++;
         rise_cyc.push_back(int'(cyc));
      end
      if (bus.SSEL === 1'b0 && p_ssel === 1'b1) begin
         ssel_fall_cyc = int'(cyc);
         ssel_fall_cnt++;
         gap_log.push_back(hi_run);
      end
      if (bus.SSEL === 1'b1 && p_ssel === 1'b0) begin
         ssel_rise_cyc = int'(cyc);
         ssel_rise_cnt++;
      end
      hi_run = (bus.SSEL === 1'b1) ? hi_run + 1 : 0;
      if (bus.tx_ready === 1'b1 && p_rdy === 1'b0) rdy_rise_cyc = int'(cyc);
      if (bus.rx_valid === 1'b1) begin
         rxv_cnt++;
         rxv_cyc = int'(cyc);
         rx_log.push_back(bus.rx_data);
      end
      p_sck  = bus.SCK;
      p_ssel = bus.SSEL;
      p_rdy  = bus.tx_ready;
   end

   task automatic send(input logic [7:0] d, input logic l, output int t);
      @(negedge clk);
      bus.tx_data  = d;
      bus.tx_last  = l;
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 400 && bus.tx_ready !== 1'b1; i++) @(negedge clk);
      chk("accept_wait", bus.tx_ready, 1'b1);
      t = int'(cyc);
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 400 && bus.busy !== 1'b0; i++) @(negedge clk);
      chk(tag, bus.busy, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t2, rb, xb, fb, sb, gb, viol, acc, bad_st;
      int gmin;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      bus.tx_last  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_sck", bus.SCK, 1'b0);
      chk("rst_ssel", bus.SSEL, 1'b1);
      chk("rst_mosi", bus.MOSI, 1'b0);
      chk("rst_tx_ready", bus.tx_ready, 1'b0);
      chk("rst_rx_valid", bus.rx_valid, 1'b0);
      chk("rst_rx_data", bus.rx_data, 8'h00);
      chk("rst_busy", bus.busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_tx_ready", bus.tx_ready, 1'b1);

      // Single byte A5, slave replies 3C
      rb = rise_cnt; xb = rxv_cnt;
      send(8'hA5, 1'b1, t);
      wait_idle("single_idle");
      chk("single_ssel_fall", ssel_fall_cyc, t + 1);
      chk("single_first_rise", rise_cyc[rb], t + 5);
      chk("single_rises", rise_cnt - rb, 8);
      chk("single_mosi", s_in, 8'hA5);
      chk("single_rxv_cyc", rxv_cyc, t + 69);
      chk("single_rxv_len", rxv_cnt - xb, 1);
      chk("single_rx_data", rx_log[xb], exp_rx(8'hA5, 8'h3C));
      chk("single_ssel_rise", ssel_rise_cyc, t + 73);
      chk("single_rdy_rise", rdy_rise_cyc, t + 77);

      // Burst 05 then 11
      rb = rise_cnt; xb = rxv_cnt; fb = ssel_fall_cnt; sb = ssel_rise_cnt;
      send(8'h05, 1'b0, t);
      send(8'h11, 1'b1, t2);
      wait_idle("burst_idle");
      chk("burst_ssel_falls", ssel_fall_cnt - fb, 1);
      chk("burst_ssel_rises", ssel_rise_cnt - sb, 1);
      chk("burst_rises", rise_cnt - rb, 16);
      chk("burst_rx_count", rxv_cnt - xb, 2);
      chk("burst_rx0", rx_log[xb], exp_rx(8'h05, 8'h3C));
      chk("burst_rx1", rx_log[xb + 1], exp_rx(8'h11, 8'h0A));
      chk("burst_wait_rise", rise_cyc[rb + 8], t2 + 4);
      chk("burst_mosi", s_in, 8'h11);

      // Stall in WAIT for 50 cycles
      xb = rxv_cnt;
      send(8'h01, 1'b0, t);
      for (int i = 0; i < 300 && rxv_cnt == xb; i++) @(negedge clk);
      chk("stall_rx_seen", rxv_cnt - xb, 1);
      bad_st = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!(bus.SSEL === 1'b0 && bus.SCK === 1'b0 && bus.tx_ready === 1'b1)) bad_st++;
      end
      chk("stall_hold", bad_st, 0);
      chk("stall_no_rx", rxv_cnt - xb, 1);
      send(8'hFF, 1'b1, t);
      wait_idle("stall_idle");
      chk("stall_rx_count", rxv_cnt - xb, 2);
      chk("stall_rx1", rx_log[xb + 1], exp_rx(8'hFF, 8'h02));
      chk("stall_mosi", s_in, 8'hFF);

      // Reset after the 3rd SCK rise
      slave_first = 8'h96;
      rb = rise_cnt; xb = rxv_cnt;
      send(8'h77, 1'b1, t);
      for (int i = 0; i < 300 && (rise_cnt - rb) < 3; i++) @(negedge clk);
      chk("mid_rises", rise_cnt - rb, 3);
      rst_n = 1'b0;
      #1;
      chk("mid_ssel", bus.SSEL, 1'b1);
      chk("mid_sck", bus.SCK, 1'b0);
      chk("mid_mosi", bus.MOSI, 1'b0);
      chk("mid_busy", bus.busy, 1'b0);
      chk("mid_rx_valid", bus.rx_valid, 1'b0);
      repeat (3) @(negedge clk);
      chk("mid_no_rx", rxv_cnt - xb, 0);
      chk("mid_rx_data", bus.rx_data, 8'h00);
      rst_n = 1'b1;
      send(8'h5A, 1'b1, t);
      wait_idle("post_rst_idle");
      chk("post_rst_rx_count", rxv_cnt - xb, 1);
      chk("post_rst_rx", bus.rx_data, exp_rx(8'h5A, 8'h96));
      chk("post_rst_mosi", s_in, 8'h5A);

      // tx_valid held high with last=1
      xb = rxv_cnt; gb = gap_log.size();
      viol = 0; acc = 0;
      @(negedge clk);
      bus.tx_data  = 8'h81;
      bus.tx_last  = 1'b1;
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 240; i++) begin
         if (bus.busy === 1'b1 && bus.tx_ready === 1'b1) viol++;
         if (bus.tx_ready === 1'b1) acc++;
         @(negedge clk);
      end
      bus.tx_valid = 1'b0;
      wait_idle("cont_idle");
      chk("cont_busy_accept", viol, 0);
      chk("cont_accepts", acc, 4);
      chk("cont_rx_count", rxv_cnt - xb, 4);
      chk("cont_rx", bus.rx_data, exp_rx(8'h81, 8'h96));
      gmin = 1000;
      for (int i = gb + 1; i < gap_log.size(); i++) if (gap_log[i] < gmin) gmin = gap_log[i];
      chk("cont_gap_count", gap_log.size() - gb, 4);
      chk("cont_gap_min_ok", (gmin >= 4), 1'b1);

`ifdef SPI_LOOPBACK_EN
      slave_mute = 1'b1;
      send(8'hC3, 1'b1, t);
      wait_idle("loop_idle");
      chk("loop_rx", bus.rx_data, 8'hC3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
